// File: rtl/sram_controller.sv
// sram_controller: stores packed-base target sequence T and streams it circularly to the PE array
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_start_read_t, i_t, o_busy      load trigger, 18-bit T stream, high while loading
//   o_T_size                         loaded length in bases
//   i_init                           rewind read and write pointers to word 0
//   i_PE_request, o_request_data     word fetch, one-cycle latency, MSB = valid
//   i_PE_send, i_send_data           in-order write-back of updated words
module sram_controller #(
    parameter int VEF_BIT        = 9,
    parameter int SRAM_ADDR      = 512,
    parameter int SRAM_WORD      = 4 + 7 * (2 + 2 * (VEF_BIT - 1)),
    parameter int MAX_T_SIZE_LOG = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start_read_t,
    input  logic [17:0]               i_t,
    output logic                      o_busy,
    output logic [MAX_T_SIZE_LOG-1:0] o_T_size,
    input  logic                      i_init,
    input  logic                      i_PE_request,
    output logic [SRAM_WORD-1:0]      o_request_data,
    input  logic                      i_PE_send,
    input  logic [SRAM_WORD-1:0]      i_send_data
);
    localparam int FW = VEF_BIT - 1;
    localparam int SW = 2 + 2 * FW;
    localparam int AW = $clog2(SRAM_ADDR);
    localparam int CW = $clog2(SRAM_ADDR + 1);

    logic [SRAM_WORD-1:0]      mem [SRAM_ADDR];
    logic                      busy_q, busy_d;
    logic [CW-1:0]             count_q, count_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [MAX_T_SIZE_LOG-1:0] t_size_q, t_size_d;
    logic [SRAM_WORD-1:0]      rdata_q, rdata_d;
    logic                      mem_we;
    logic [AW-1:0]             mem_addr;
    logic [SRAM_WORD-1:0]      mem_wdata;
    logic                      active, rd_en, wr_en, last_word;

    function automatic logic [SRAM_WORD-1:0] expand(input logic [17:0] t);
        logic [SRAM_WORD-1:0] w;
        w = '0;
        w[SRAM_WORD-1 -: 4] = t[17:14];
        for (int k = 0; k < 7; k++) w[k*SW + 2*FW +: 2] = t[2*k +: 2];
        return w;
    endfunction

    // pointers wrap over the loaded word count, not the array capacity
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p, input logic [CW-1:0] cnt);
        return (CW'(p) == cnt - CW'(1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        active    = !busy_q && count_q != '0;
        rd_en     = active && i_PE_request;
        wr_en     = active && i_PE_send;
        last_word = i_t[16:14] != 3'd7 || count_q == CW'(SRAM_ADDR - 1);
        busy_d    = busy_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        t_size_d  = t_size_q;
        rdata_d   = '0;
        mem_we    = 1'b0;
        mem_addr  = wr_ptr_q;
        mem_wdata = i_send_data;
        if (busy_q) begin
            mem_we    = 1'b1;
            mem_addr  = AW'(count_q);
            mem_wdata = expand(i_t);
            count_d   = count_q + CW'(1);
            if (last_word) begin
                busy_d   = 1'b0;
                t_size_d = MAX_T_SIZE_LOG'(7 * count_q) + MAX_T_SIZE_LOG'(i_t[16:14]);
            end
        end
        if (rd_en) begin
            // write-through so a same-address write-back is seen immediately
            rdata_d  = (wr_en && wr_ptr_q == rd_ptr_q) ? i_send_data : mem[rd_ptr_q];
            rd_ptr_d = next_ptr(rd_ptr_q, count_q);
        end
        if (wr_en) begin
            mem_we   = 1'b1;
            wr_ptr_d = next_ptr(wr_ptr_q, count_q);
        end
        if (!busy_q && i_init) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            rdata_d  = '0;
        end
        if (!busy_q && i_start_read_t) begin
            busy_d   = 1'b1;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            t_size_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            t_size_q <= '0;
            rdata_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            t_size_q <= t_size_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign o_busy         = busy_q;
    assign o_T_size       = t_size_q;
    assign o_request_data = rdata_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed self-checking bench for sram_controller
module tb_sram_controller;
    localparam int SW = 130;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start_read_t = 1'b0;
    logic [17:0]   i_t = '0;
    logic          o_busy;
    logic [11:0]   o_T_size;
    logic          i_init = 1'b0;
    logic          i_PE_request = 1'b0;
    logic [SW-1:0] o_request_data;
    logic          i_PE_send = 1'b0;
    logic [SW-1:0] i_send_data = '0;
    int            total = 0;
    int            bad = 0;
    logic [17:0]   tv [6];

    sram_controller dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start_read_t(i_start_read_t),
        .i_t(i_t),
        .o_busy(o_busy),
        .o_T_size(o_T_size),
        .i_init(i_init),
        .i_PE_request(i_PE_request),
        .o_request_data(o_request_data),
        .i_PE_send(i_PE_send),
        .i_send_data(i_send_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] mk(input logic [17:0] t, input logic [7:0] f);
        logic [SW-1:0] w;
        w = SW'(t[17:14]);
        for (int k = 6; k >= 0; k--) w = {w[SW-19:0], t[2*k+1 -: 2], f, f};
        return w;
    endfunction

    initial begin
        logic [SW-1:0] e;
        logic [SW-1:0] fwd;
        logic [13:0]   pat;
        logic          prev;
        int            n;
        int            idx;
        tv[0] = {1'b1, 3'd7, 14'h1B39};
        tv[1] = {1'b1, 3'd7, 14'h0F0F};
        tv[2] = {1'b1, 3'd7, 14'h3FFF};
        tv[3] = {1'b1, 3'd7, 14'h0000};
        tv[4] = {1'b1, 3'd7, 14'h2A55};
        tv[5] = {1'b1, 3'd3, 14'h3F00};
        fwd   = {2'b10, {4{32'hA5C3_0F96}}};
        #12;
        chk("rst_busy", SW'(o_busy), '0);
        chk("rst_tsize", SW'(o_T_size), '0);
        chk("rst_data", o_request_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        i_PE_request = 1'b1;
        @(negedge clk);
        chk("empty_req", o_request_data, '0);
        i_start_read_t = 1'b1;
        @(negedge clk);
        i_start_read_t = 1'b0;
        n = 0;
        while (o_busy && n < 20) begin
            i_t = tv[n < 6 ? n : 5];
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", SW'(n), SW'(6));
        chk("tsize6", SW'(o_T_size), SW'(38));
        chk("busy_req", o_request_data, '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("p1_w%0d", k), o_request_data, mk(tv[k], 8'd0));
            i_PE_send = 1'b1;
            i_send_data = mk(tv[k], 8'(k + 1));
        end
        idx = 0;
        prev = 1'b1;
        pat = 14'b10110111011101;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            e = prev ? mk(tv[idx], 8'(idx + 1)) : '0;
            if (prev) idx = (idx == 5) ? 0 : idx + 1;
            chk($sformatf("p2_c%0d", c), o_request_data, e);
            i_PE_send = 1'b0;
            i_PE_request = pat[c];
            prev = pat[c];
        end
        i_init = 1'b1;
        i_PE_request = 1'b1;
        @(negedge clk);
        chk("init_data", o_request_data, '0);
        i_init = 1'b0;
        i_PE_send = 1'b1;
        i_send_data = fwd;
        @(negedge clk);
        chk("fwd", o_request_data, fwd);
        i_PE_send = 1'b0;
        @(negedge clk);
        chk("init_w1", o_request_data, mk(tv[1], 8'd2));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", o_request_data, '0);
        chk("arst_tsize", SW'(o_T_size), '0);
        i_PE_request = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i_start_read_t = 1'b1;
        @(negedge clk);
        i_start_read_t = 1'b0;
        n = 0;
        while (o_busy && n < 1000) begin
            i_t = {1'b1, 3'd7, 14'(n)};
            i_start_read_t = (n == 100);
            n++;
            @(negedge clk);
        end
        i_start_read_t = 1'b0;
        chk("full_busy", SW'(n), SW'(512));
        chk("full_tsize", SW'(o_T_size), SW'(3584));
        i_PE_request = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("full_w%0d", k), o_request_data, mk({1'b1, 3'd7, 14'(k)}, 8'd0));
        end
        i_init = 1'b1;
        @(negedge clk);
        chk("init_mid", o_request_data, '0);
        i_init = 1'b0;
        @(negedge clk);
        chk("init_w0", o_request_data, mk({1'b1, 3'd7, 14'd0}, 8'd0));
        i_PE_request = 1'b0;
        i_start_read_t = 1'b1;
        @(negedge clk);
        i_start_read_t = 1'b0;
        repeat (3) @(negedge clk);
        chk("midload_busy", SW'(o_busy), SW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_load_busy", SW'(o_busy), '0);
        chk("rst_load_tsize", SW'(o_T_size), '0);
        @(negedge clk);
        rst_n = 1'b1;
        i_PE_request = 1'b1;
        @(negedge clk);
        chk("post_rst_req", o_request_data, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- On-chip storage and sequencing block for the target sequence T, which is stored as packed 2-bit bases.
- Loads T from an external 18-bit stream, expands each word into a wide PE word with zeroed per-base score fields, and stores it in an internal word array.
- Serves words one per cycle to the PE array on request and accepts updated words written back in the same order.
- Read and write pointers wrap circularly over the loaded length, so T can be streamed through the PEs any number of passes.

Parameters:
- VEF_BIT, 9: score width; each per-base field is FW = VEF_BIT-1 = 8 bits.
- SRAM_ADDR, 512: word capacity of the array.
- SRAM_WORD, 4+7*(2+2*FW) = 130: expanded word width.
- MAX_T_SIZE_LOG, 12: width of o_T_size; must hold 7*SRAM_ADDR.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start_read_t  in  1  one-cycle pulse; starts loading T.
- i_t  in  18  T input word: [17]=valid, [16:14]=base count cnt (7=full word), [13:0]=bases 6..0, two bits each, base 6 in [13:12].
- o_busy  out  1  high while loading.
- o_T_size  out  MAX_T_SIZE_LOG  loaded length in bases.
- i_init  in  1  one-cycle pulse; rewinds both pointers to word 0.
- i_PE_request  in  1  PE wants the next word.
- o_request_data  out  SRAM_WORD  delivered word; MSB=1 means valid this cycle.
- i_PE_send  in  1  write-back strobe.
- i_send_data  in  SRAM_WORD  write-back word.

Behaviour:
- Reset: o_busy=0, o_request_data=0, o_T_size=0; word count, rd_ptr and wr_ptr = 0; array contents don't-care.
- Expansion: stored word = {t[17:14], then for k=6 down to 0: t[2k+1:2k], FW'b0, FW'b0}.
- Load start: i_start_read_t sampled high while !o_busy sets o_busy=1 at the next edge and clears count, pointers and o_T_size. A start while busy is ignored.
- Load cycle: every edge with o_busy=1 writes expand(i_t) at address count and increments count. Exactly one word is stored per busy cycle.
- Load end: o_busy clears on the same edge that stores a word with cnt!=7, or the word at address SRAM_ADDR-1.
- o_T_size: at load end, o_T_size = 7*(count-1) + cnt of the last word.
- Loading does not inspect i_t[17]; it is stored as is.
- Read: at an edge where i_PE_request=1, !o_busy and count>0:
  - o_request_data <= mem[rd_ptr] (one-cycle latency, throughput one word per cycle).
  - rd_ptr <= (rd_ptr==count-1) ? 0 : rd_ptr+1.
  - Otherwise o_request_data <= 0.
- Write: at an edge where i_PE_send=1, !o_busy and count>0:
  - mem[wr_ptr] <= i_send_data.
  - wr_ptr advances and wraps exactly like rd_ptr.
- Read-during-write: same-edge read and write at the same address delivers i_send_data (write-through forwarding).
- Stall: request and send are independent. Dropping i_PE_request for any number of cycles holds rd_ptr.
- i_init while !o_busy: rd_ptr=wr_ptr=0 and o_request_data=0 next edge. Ignored while busy. Takes priority over a same-cycle read/write pointer advance.
- Request or send while busy or with count==0: no pointer movement; o_request_data=0.
- Asynchronous reset mid-load or mid-pass aborts immediately to the reset state.

Test Plan:
- Reset then pulse i_start_read_t, with i_t supplied each busy cycle; 5 words with cnt=7 then a word with cnt=3 -> o_busy high exactly 6 cycles, o_T_size=38.
- Hold i_PE_request=1 -> 6 consecutive valid words equal to expand(i_t[n]), all score fields 0, in load order.
- First pass: write back each word n with all fields set to n, sent the cycle after it is received. Second pass -> words return with fields = n, starting again at word 0 after the wrap.
- Toggle i_PE_request mid-pass -> no duplicated or skipped words; invalid cycles show MSB=0.
- Load exactly SRAM_ADDR full words -> busy ends at the full array, o_T_size=7*SRAM_ADDR; i_init mid-pass -> next delivered word is word 0.
- Assert rst_n low during load -> o_busy=0 and o_T_size=0 immediately; a request returns MSB=0.
